// File: rtl/ps2_key_receiver_if.sv
// CPU-side load port of the PS/2 key receiver.
// The receiver drives the FIFO head and status flags, and the CPU drives iRead.
interface ps2_key_receiver_if;
  logic       iRead;
  logic [7:0] oData;
  logic       oValid;
  logic       oFull;
  logic       oOverflow;
  logic       oFrameError;

  modport master (
    output iRead,
    input  oData, oValid, oFull,
    input  oOverflow, oFrameError
  );

  modport slave (
    input  iRead,
    output oData, oValid, oFull,
    output oOverflow, oFrameError
  );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver with a first-word-fall-through scan-code FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iPs2Clk,
  input  logic iPs2Data,
  ps2_key_receiver_if.slave cpu
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          dat_s1_q, dat_s2_q;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic fall, bit_in, parity_ok, push;
  logic empty, full, pop, wr;

  assign fall   = clk_s3_q & ~clk_s2_q;
  assign bit_in = dat_s2_q;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, par_q};
`else
  // parity bit is captured but never gates acceptance
  assign parity_ok = par_q | ~par_q;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    idle_cnt_d = idle_cnt_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
    if (state_q != IDLE)
      idle_cnt_d = idle_cnt_q + TW'(1);
    if (fall) begin
      idle_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7)
            state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bit_in && parity_ok)
            push = 1'b1;
          else
            ferr_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE &&
                 idle_cnt_q == TW'(TIMEOUT_CYCLES)) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      shift_d    = 8'h00;
      idle_cnt_d = '0;
      ferr_d     = 1'b1;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = cpu.iRead & ~empty;
  // a pop frees the head slot in the same edge, so full+pop can still accept
  assign wr    = push & (~full | pop);

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, wr};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    ovf_d  = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_s3_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      idle_cnt_q <= '0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      clk_s1_q   <= iPs2Clk;
      clk_s2_q   <= clk_s1_q;
      clk_s3_q   <= clk_s2_q;
      dat_s1_q   <= iPs2Data;
      dat_s2_q   <= dat_s1_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idle_cnt_q <= idle_cnt_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr)
      mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  assign cpu.oData       = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign cpu.oValid      = ~empty;
  assign cpu.oFull       = full;
  assign cpu.oOverflow   = ovf_q;
  assign cpu.oFrameError = ferr_q;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver with a scan-code scoreboard queue.
// Works with or without PS2_PARITY_CHECK_EN defined.
module tb_ps2_key_receiver;
  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int H     = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic iPs2Clk = 1'b1;
  logic iPs2Data = 1'b1;

  ps2_key_receiver_if bus ();

  ps2_key_receiver #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iPs2Clk  (iPs2Clk),
    .iPs2Data (iPs2Data),
    .cpu      (bus.slave)
  );

  always #5 Clock = ~Clock;

  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed %0h expected nothing queued",
             tag, bus.oData);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.oData, e);
    end
  endtask

  task automatic pop_check(input string tag);
    int w;
    w = 0;
    while (!bus.oValid && w < 50) begin
      step(1);
      w++;
    end
    if (!bus.oValid) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed oValid 0 expected 1 within 50 cycles", tag);
    end else begin
      chk_head(tag);
      bus.iRead = 1'b1;
      step(1);
      bus.iRead = 1'b0;
    end
  endtask

  task automatic do_reset();
    iPs2Clk   = 1'b1;
    iPs2Data  = 1'b1;
    bus.iRead = 1'b0;
    Reset     = 1'b1;
    step(2);
    Reset     = 1'b0;
    exp_q.delete();
    step(2);
  endtask

  task automatic ps2_bit(input logic b, input bit rd);
    iPs2Data = b;
    step(H);
    iPs2Clk = 1'b0;
    if (rd) begin
      step(2);
      bus.iRead = 1'b1;
      chk_head("pop_at_push");
      step(1);
      bus.iRead = 1'b0;
      step(H - 3);
    end else begin
      step(H);
    end
    iPs2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stp, input bit rd);
    bit good;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      ps2_bit(d[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(stp, rd);
    step(H);
`ifdef PS2_PARITY_CHECK_EN
    good = stp && (^{d, par});
`else
    good = stp;
`endif
    if (good && exp_q.size() < DEPTH)
      exp_q.push_back(d);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1, 1'b0);
  endtask

  initial begin
    bus.iRead = 1'b0;
    do_reset();
    chk("rst_valid", {7'd0, bus.oValid}, 8'd0);
    chk("rst_full", {7'd0, bus.oFull}, 8'd0);
    chk("rst_ovf", {7'd0, bus.oOverflow}, 8'd0);
    chk("rst_ferr", {7'd0, bus.oFrameError}, 8'd0);
    chk("rst_data", bus.oData, 8'h00);

    bus.iRead = 1'b1;
    step(2);
    bus.iRead = 1'b0;
    chk("empty_read_valid", {7'd0, bus.oValid}, 8'd0);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("single_valid", {7'd0, bus.oValid}, 8'd1);
    pop_check("single_data");
    chk("single_drained", {7'd0, bus.oValid}, 8'd0);

    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    pop_check("order_f0");
    pop_check("order_1c");
    chk("order_ferr", {7'd0, bus.oFrameError}, 8'd0);

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    chk("badpar_valid", {7'd0, bus.oValid}, 8'd0);
    chk("badpar_ferr", {7'd0, bus.oFrameError}, 8'd1);
`else
    chk("badpar_ferr", {7'd0, bus.oFrameError}, 8'd0);
    pop_check("badpar_data");
`endif

    do_reset();
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk("badstop_valid", {7'd0, bus.oValid}, 8'd0);
    chk("badstop_ferr", {7'd0, bus.oFrameError}, 8'd1);

    do_reset();
    for (int i = 1; i <= 5; i++)
      send_good(8'(i));
    chk("ovf_full", {7'd0, bus.oFull}, 8'd1);
    chk("ovf_flag", {7'd0, bus.oOverflow}, 8'd1);
    for (int i = 0; i < DEPTH; i++)
      pop_check("ovf_pop");
    chk("ovf_drained", {7'd0, bus.oValid}, 8'd0);

    do_reset();
    for (int i = 0; i < DEPTH; i++)
      send_good(8'h11 + 8'(i));
    chk("simul_full_pre", {7'd0, bus.oFull}, 8'd1);
    send_frame(8'h55, ~^8'h55, 1'b1, 1'b1);
    chk("simul_full_post", {7'd0, bus.oFull}, 8'd1);
    chk("simul_ovf", {7'd0, bus.oOverflow}, 8'd0);
    for (int i = 0; i < DEPTH; i++)
      pop_check("simul_pop");
    chk("simul_drained", {7'd0, bus.oValid}, 8'd0);

    do_reset();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    iPs2Data = 1'b1;
    step(TMO + 10);
    chk("tmo_ferr", {7'd0, bus.oFrameError}, 8'd1);
    chk("tmo_valid", {7'd0, bus.oValid}, 8'd0);
    send_good(8'h1C);
    pop_check("tmo_recover");

    do_reset();
    for (int i = 0; i < 5; i++)
      ps2_bit(i == 0 ? 1'b0 : 1'b1, 1'b0);
    do_reset();
    chk("midrst_ferr", {7'd0, bus.oFrameError}, 8'd0);
    chk("midrst_valid", {7'd0, bus.oValid}, 8'd0);
    send_good(8'h5A);
    pop_check("midrst_recover");
    chk("midrst_ferr_after", {7'd0, bus.oFrameError}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the scan-code FIFO depth in bytes; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the maximum number of Clock cycles allowed between PS/2 clock falling edges within one frame.
REQ-003 Port Clock, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port iPs2Clk, input, 1 bit: PS/2 clock line, asynchronous to Clock.
REQ-006 Port iPs2Data, input, 1 bit: PS/2 data line, asynchronous to Clock.
REQ-007 Port iRead, input, 1 bit: pop request from the CPU load path.
REQ-008 Port oData, output, 8 bits: scan code at the FIFO head.
REQ-009 Port oValid, output, 1 bit: FIFO not empty.
REQ-010 Port oFull, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-011 Port oOverflow, output, 1 bit: sticky flag, set when a good frame is dropped because the FIFO is full.
REQ-012 Port oFrameError, output, 1 bit: sticky flag, set on a stop-bit, parity or timeout error.

Function
REQ-013 iPs2Clk and iPs2Data SHALL each pass through a two-flop synchronizer; a third flop on the clock line SHALL detect falling edges (sync'd previous = 1, sync'd current = 0).
REQ-014 All bit sampling SHALL use the synchronized iPs2Data value in the cycle the falling edge is detected.
REQ-015 The receive FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL advance only on detected falling edges.
REQ-016 In IDLE, a falling edge with data = 0 SHALL enter DATA with the bit counter at 0; a falling edge with data = 1 SHALL leave the FSM in IDLE with no error.
REQ-017 In DATA, each falling edge SHALL shift the data bit into the shift register LSB-first; the eighth bit SHALL move the FSM to PARITY.
REQ-018 In PARITY, the FSM SHALL store the sampled bit and move to STOP.
REQ-019 In STOP, the FSM SHALL return to IDLE; the frame is good if stop = 1 and the parity check passes (see REQ-031).
REQ-020 A good frame SHALL be written to the FIFO on the clock edge after the stop-bit falling edge is detected.
REQ-021 A bad frame SHALL be discarded and SHALL set oFrameError.
REQ-022 An idle counter SHALL clear on every detected falling edge and increment otherwise while the FSM is not in IDLE.
REQ-023 When the idle counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, discard the partial byte and set oFrameError.
REQ-024 The FIFO SHALL be first-word fall-through: oData always equals the head entry and is valid when oValid = 1.
REQ-025 iRead = 1 with oValid = 1 SHALL pop one entry at the next edge; iRead while empty SHALL be ignored.
REQ-026 On a push while full with no pop, the new byte SHALL be dropped and oOverflow set; the FIFO contents SHALL be unchanged.
REQ-027 On a simultaneous push and pop, including when full, both SHALL succeed, occupancy SHALL be unchanged and oOverflow SHALL not be set.
REQ-028 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty SHALL be derived from the MSB comparison.

Reset
REQ-029 On Reset = 1 at a rising edge, the following SHALL all take effect:
- FSM to IDLE; bit counter, idle counter and shift register to 0.
- FIFO pointers to 0.
- oValid = 0, oFull = 0, oOverflow = 0, oFrameError = 0, oData = 8'h00.
- Synchronizer flops to 1 (idle bus).
REQ-030 Reset asserted mid-frame SHALL abort the frame without setting any flag; the next start bit after release SHALL be received normally.

Configuration
REQ-031 With macro PS2_PARITY_CHECK_EN defined, a frame whose 8 data bits plus parity bit hold an even number of ones SHALL be treated as bad.
REQ-032 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and only the stop bit and timeout SHALL determine a bad frame.

Verification
REQ-033 Frame 0x1C, parity 0, stop 1 -> oValid = 1 and oData = 8'h1C; after one iRead pulse -> oValid = 0.
REQ-034 Frames 0xF0 (parity 1) then 0x1C (parity 0) -> pop order is 0xF0 then 0x1C; oFrameError stays 0.
REQ-035 Frame 0x1C with parity 1 -> with PS2_PARITY_CHECK_EN: FIFO stays empty and oFrameError = 1; without the macro: oData = 8'h1C.
REQ-036 Five good frames 0x01..0x05 with FIFO_DEPTH = 4 and no reads -> oFull = 1, oOverflow = 1, pops return 0x01..0x04.
REQ-037 FIFO full, then iRead held high in the cycle a 0x55 push occurs -> occupancy stays 4, oOverflow = 0, last pop = 0x55.
REQ-038 Start bit plus 3 data bits, then clock held high for TIMEOUT_CYCLES+10 cycles -> FSM in IDLE, oFrameError = 1; a following 0x1C frame is received correctly.
